// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, address and
// byte widths, and the R/W bit polarity.
package i2c_pkg;
    localparam int   I2C_ADDR_W  = 7;
    localparam logic I2C_RW_READ = 1'b1;
    localparam int   I2C_BYTE_W  = 8;
    localparam int   I2C_CNT_W   = $clog2(I2C_BYTE_W);
    localparam logic [I2C_CNT_W-1:0] I2C_LAST_BIT = I2C_CNT_W'(I2C_BYTE_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_WAIT_STOP
    } i2c_state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes scl/sda into the clk domain and produces registered bus events.
//   clk, rst            : system clock, synchronous active-high reset
//   scl, sda            : raw bus pins
//   scl_rise, scl_fall  : one-cycle pulses on synchronized scl edges
//   start_det, stop_det : one-cycle pulses for START / STOP conditions
//   sda_s               : synchronized sda, time-aligned with the event pulses
// Every event appears SYNC_STAGES+1 clk cycles after the pin change.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic scl_d;
    logic sda_d;
    logic scl_q;
    logic sda_q;

    assign scl_q = scl_ff[SYNC_STAGES-1];
    assign sda_q = sda_ff[SYNC_STAGES-1];
    // sda_d lags sda_q by the same cycle the event registers add.
    assign sda_s = sda_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus level is high on both lines; resetting to 1 avoids
            // a spurious START/STOP coming out of reset.
            scl_ff    <= '1;
            sda_ff    <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_ff    <= {scl_ff[SYNC_STAGES-2:0], scl};
            sda_ff    <= {sda_ff[SYNC_STAGES-2:0], sda};
            scl_d     <= scl_q;
            sda_d     <= sda_q;
            scl_rise  <= scl_q & ~scl_d;
            scl_fall  <= ~scl_q & scl_d;
            start_det <= scl_q & scl_d & sda_d & ~sda_q;
            stop_det  <= scl_q & scl_d & ~sda_d & sda_q;
        end
    end
endmodule

// File: rtl/i2c_target.sv
// I2C target responding to DEV_ADDR. Write bytes are delivered on
// wr_data/wr_valid; read bytes are requested with rd_req and taken from
// rd_data at the following scl falling edge.
//   clk, rst  : system clock (>=10x scl), synchronous active-high reset
//   scl       : bus clock input (no stretching)
//   sda       : open-drain bus data, driven 0 or released
//   wr_data   : last byte received in a write; wr_valid pulses with it
//   rd_req    : pulse asking for the next read byte on rd_data
//   busy      : addressed transfer in progress
//   done      : pulse on STOP ending an addressed transfer
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [I2C_BYTE_W-1:0] wr_data,
    output logic                  wr_valid,
    output logic                  rd_req,
    input  logic [I2C_BYTE_W-1:0] rd_data,
    output logic                  busy,
    output logic                  done
);
    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_state_e            state;
    logic [I2C_CNT_W-1:0]  bit_cnt;
    logic [I2C_BYTE_W-2:0] shreg;     // bit 7 is always on the wire or in sda_s
    logic                  sda_oe;    // 1 = pull sda low
    logic                  rw;
    logic                  load_pend; // master ACKed: load rd_data at next fall
    logic [I2C_BYTE_W-1:0] rx_byte;

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign rx_byte = {shreg, sda_s};

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            load_pend <= 1'b0;
            wr_data   <= '0;
            wr_valid  <= 1'b0;
            rd_req    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            done     <= 1'b0;
            if (stop_det) begin
                state     <= ST_IDLE;
                sda_oe    <= 1'b0;
                load_pend <= 1'b0;
                busy      <= 1'b0;
                done      <= busy;
            end else if (start_det) begin
                // busy is kept until the new address is resolved
                state     <= ST_ADDR;
                bit_cnt   <= '0;
                shreg     <= '0;
                sda_oe    <= 1'b0;
                load_pend <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shreg   <= rx_byte[I2C_BYTE_W-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == I2C_LAST_BIT) begin
                            if (rx_byte[I2C_BYTE_W-1:1] == DEV_ADDR) begin
                                state <= ST_ADDR_ACK;
                                busy  <= 1'b1;
                                rw    <= rx_byte[0];
                            end else begin
                                state <= ST_WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    // ACK slot: first fall starts the drive, second fall ends it.
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw == I2C_RW_READ) begin
                            state   <= ST_READ;
                            bit_cnt <= '0;
                            shreg   <= rd_data[I2C_BYTE_W-2:0];
                            sda_oe  <= ~rd_data[I2C_BYTE_W-1];
                        end else begin
                            state   <= ST_WRITE;
                            bit_cnt <= '0;
                            sda_oe  <= 1'b0;
                        end
                    end else if (scl_rise && sda_oe && rw == I2C_RW_READ) begin
                        rd_req <= 1'b1;
                    end
                    ST_WRITE: if (scl_rise) begin
                        shreg   <= rx_byte[I2C_BYTE_W-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == I2C_LAST_BIT) begin
                            wr_data  <= rx_byte;
                            wr_valid <= 1'b1;
                            state    <= ST_WRITE_ACK;
                        end
                    end
                    ST_WRITE_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WRITE;
                        end
                    end
                    ST_READ: if (scl_fall) begin
                        if (load_pend) begin
                            load_pend <= 1'b0;
                            bit_cnt   <= '0;
                            shreg     <= rd_data[I2C_BYTE_W-2:0];
                            sda_oe    <= ~rd_data[I2C_BYTE_W-1];
                        end else begin
                            sda_oe <= ~shreg[I2C_BYTE_W-2];
                            shreg  <= {shreg[I2C_BYTE_W-3:0], 1'b0};
                        end
                    end else if (scl_rise && !load_pend) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == I2C_LAST_BIT) state <= ST_READ_ACK;
                    end
                    ST_READ_ACK: if (scl_fall) begin
                        sda_oe <= 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_s) begin
                            rd_req    <= 1'b1;
                            load_pend <= 1'b1;
                            state     <= ST_READ;
                        end else begin
                            state <= ST_WAIT_STOP;
                        end
                    end
                    default: ;  // IDLE and WAIT_STOP only leave on START/STOP
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;
    localparam logic [6:0] DEV = 7'h50;

    typedef struct packed {
        logic        addr_nack;
        logic        busy_a;
        logic [2:0]  n_dnack;
        logic [2:0]  n_wr;
        logic [31:0] wr;
        logic [2:0]  n_rd;
        logic [31:0] rd;
        logic [2:0]  n_rdreq;
        logic [1:0]  n_done;
        logic        bus_rel;
    } exp_t;

    typedef struct packed {
        logic [7:0]  ab;
        logic [2:0]  n;
        logic [31:0] d;
        exp_t        e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req),
        .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Bus-side observers, owned by this process only.
    logic [7:0]  wr_q[$];
    int          done_cnt = 0;
    int          busy_low_cnt = 0;
    int          rd_cnt = 0;
    int          rd_base = 0;
    logic [31:0] rd_src = '0;

    initial begin
        int k;
        rd_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (wr_valid) wr_q.push_back(wr_data);
            if (done) done_cnt++;
            if (!busy) busy_low_cnt++;
            if (rd_req) begin
                k = rd_cnt - rd_base;
                rd_data = (k < 4) ? rd_src[k*8 +: 8] : 8'hFF;
                rd_cnt++;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic r);
        m_low = ~b;
        wt(5); scl = 1'b1;
        wt(5); r = sda;
        wt(5); scl = 1'b0;
        wt(5);
    endtask

    task automatic bus_start();
        m_low = 1'b0; wt(5);
        scl = 1'b1;   wt(5);
        m_low = 1'b1; wt(5);
        scl = 1'b0;   wt(5);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wt(5);
        scl = 1'b1;   wt(5);
        m_low = 1'b0; wt(10);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, ack);
    endtask

    task automatic rd_byte(input logic m_nack, output logic [7:0] b, output logic ackbus);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            b[i] = r;
        end
        bit_io(m_nack, ackbus);
    endtask

    // Transaction-level reference: matched address -> ACK, writes deliver
    // every byte, reads return the supplied bytes with one request per byte.
    function automatic exp_t model(input logic [7:0] ab, input logic [2:0] n, input logic [31:0] d);
        exp_t e;
        e = '0;
        e.bus_rel = 1'b1;
        if (ab[7:1] != DEV) begin
            e.addr_nack = 1'b1;
            return e;
        end
        e.busy_a = 1'b1;
        e.n_done = 2'd1;
        if (!ab[0]) begin
            e.n_wr = n;
            e.wr   = d;
        end else begin
            e.n_rd    = n;
            e.rd      = d;
            e.n_rdreq = n;
        end
        return e;
    endfunction

    task automatic run_xfer(input logic [7:0] ab, input logic [2:0] n, input logic [31:0] d, output exp_t a);
        int wb, rq0, dn0;
        logic ack, r;
        logic [7:0] b;
        a = '0;
        a.bus_rel = 1'b1;
        wb = wr_q.size(); rq0 = rd_cnt; dn0 = done_cnt;
        rd_src = d; rd_base = rd_cnt;
        bus_start();
        wr_byte(ab, ack);
        a.addr_nack = ack;
        a.busy_a = busy;
        if (!ack) begin
            for (int i = 0; i < int'(n); i++) begin
                if (!ab[0]) begin
                    wr_byte(d[i*8 +: 8], r);
                    a.n_dnack = a.n_dnack + 3'(r);
                end else begin
                    rd_byte(i == int'(n) - 1, b, r);
                    a.rd[i*8 +: 8] = b;
                    if (i == int'(n) - 1) a.bus_rel = r;
                end
            end
        end
        bus_stop();
        wt(10);
        a.n_wr = 3'(wr_q.size() - wb);
        for (int i = 0; i < wr_q.size() - wb && i < 4; i++) a.wr[i*8 +: 8] = wr_q[wb + i];
        a.n_rdreq = 3'(rd_cnt - rq0);
        a.n_done  = 2'(done_cnt - dn0);
    endtask

    task automatic cmp(input string t, input exp_t a, input exp_t e);
        chk({t, " addr_ack"}, a.addr_nack, e.addr_nack);
        chk({t, " busy"}, a.busy_a, e.busy_a);
        chk({t, " data_acks"}, a.n_dnack, e.n_dnack);
        chk({t, " wr_valid_cnt"}, a.n_wr, e.n_wr);
        for (int i = 0; i < int'(e.n_wr) && i < 4; i++)
            chk($sformatf("%s wr_data[%0d]", t, i), a.wr[i*8 +: 8], e.wr[i*8 +: 8]);
        for (int i = 0; i < int'(e.n_rd) && i < 4; i++)
            chk($sformatf("%s rd_bus[%0d]", t, i), a.rd[i*8 +: 8], e.rd[i*8 +: 8]);
        chk({t, " rd_req_cnt"}, a.n_rdreq, e.n_rdreq);
        chk({t, " done_cnt"}, a.n_done, e.n_done);
        chk({t, " sda_released"}, a.bus_rel, e.bus_rel);
    endtask

    initial begin
        vec_t vecs[4];
        exp_t a, e;
        logic ack, r;
        logic [7:0] b;
        logic [6:0] ad;
        int wb, dn0, bl0, rq0;

        vecs[0] = '{ab: 8'hA0, n: 3'd2, d: 32'h0000_C33C,
                    e: '{addr_nack: 1'b0, busy_a: 1'b1, n_dnack: 3'd0, n_wr: 3'd2, wr: 32'h0000_C33C,
                         n_rd: 3'd0, rd: 32'h0, n_rdreq: 3'd0, n_done: 2'd1, bus_rel: 1'b1}};
        vecs[1] = '{ab: 8'hA2, n: 3'd1, d: 32'h0000_0055,
                    e: '{addr_nack: 1'b1, busy_a: 1'b0, n_dnack: 3'd0, n_wr: 3'd0, wr: 32'h0,
                         n_rd: 3'd0, rd: 32'h0, n_rdreq: 3'd0, n_done: 2'd0, bus_rel: 1'b1}};
        vecs[2] = '{ab: 8'hA1, n: 3'd2, d: 32'h0000_965A,
                    e: '{addr_nack: 1'b0, busy_a: 1'b1, n_dnack: 3'd0, n_wr: 3'd0, wr: 32'h0,
                         n_rd: 3'd2, rd: 32'h0000_965A, n_rdreq: 3'd2, n_done: 2'd1, bus_rel: 1'b1}};
        vecs[3] = '{ab: 8'hA3, n: 3'd1, d: 32'h0000_00FF,
                    e: '{addr_nack: 1'b1, busy_a: 1'b0, n_dnack: 3'd0, n_wr: 3'd0, wr: 32'h0,
                         n_rd: 3'd0, rd: 32'h0, n_rdreq: 3'd0, n_done: 2'd0, bus_rel: 1'b1}};

        // Reset state
        wt(3);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset wr_valid", wr_valid, 1'b0);
        chk("reset rd_req", rd_req, 1'b0);
        chk("reset wr_data", wr_data, 8'h00);
        chk("reset sda", sda, 1'b1);
        rst = 1'b0;
        wt(10);

        for (int v = 0; v < 4; v++) begin
            run_xfer(vecs[v].ab, vecs[v].n, vecs[v].d, a);
            cmp($sformatf("vec%0d", v), a, vecs[v].e);
        end

        // Write 0x11, repeated START, read one byte
        wb = wr_q.size(); dn0 = done_cnt; rq0 = rd_cnt;
        rd_src = 32'h0000_00E7; rd_base = rd_cnt;
        bus_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h11, ack);
        chk("rs data ack", ack, 1'b0);
        bl0 = busy_low_cnt;
        bus_start();
        wr_byte(8'hA1, ack);
        chk("rs busy held", busy_low_cnt - bl0, 0);
        chk("rs read addr ack", ack, 1'b0);
        rd_byte(1'b1, b, r);
        chk("rs read data", b, 8'hE7);
        bus_stop();
        wt(10);
        chk("rs wr_valid_cnt", wr_q.size() - wb, 1);
        chk("rs wr_data", wr_q[wb], 8'h11);
        chk("rs rd_req_cnt", rd_cnt - rq0, 1);
        chk("rs done_cnt", done_cnt - dn0, 1);

        // Reset in the middle of a data byte
        dn0 = done_cnt;
        bus_start();
        wr_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) bit_io(1'b0, r);
        m_low = 1'b0;
        wt(2);
        rst = 1'b1;
        wt(1);
        rst = 1'b0;
        chk("mid-rst busy", busy, 1'b0);
        chk("mid-rst wr_data", wr_data, 8'h00);
        chk("mid-rst wr_valid", wr_valid, 1'b0);
        chk("mid-rst rd_req", rd_req, 1'b0);
        chk("mid-rst done", done, 1'b0);
        chk("mid-rst sda", sda, 1'b1);
        wt(10);
        chk("mid-rst no done", done_cnt - dn0, 0);
        run_xfer(8'hA0, 3'd1, 32'h0000_0077, a);
        cmp("post-rst", a, model(8'hA0, 3'd1, 32'h0000_0077));

        // STOP in the middle of a data byte
        wb = wr_q.size(); dn0 = done_cnt;
        bus_start();
        wr_byte(8'hA0, ack);
        bit_io(1'b1, r); bit_io(1'b0, r); bit_io(1'b1, r);
        bus_stop();
        wt(10);
        chk("mid-stop wr_valid_cnt", wr_q.size() - wb, 0);
        chk("mid-stop done_cnt", done_cnt - dn0, 1);
        chk("mid-stop busy", busy, 1'b0);

        // Randomized transfers against the reference model
        for (int t = 0; t < 16; t++) begin
            logic [7:0]  ab;
            logic [2:0]  n;
            logic [31:0] d;
            ad = ($urandom_range(0, 1) == 1) ? DEV : 7'($urandom_range(0, 127));
            ab = {ad, 1'($urandom_range(0, 1))};
            n  = 3'($urandom_range(1, 3));
            d  = $urandom;
            e  = model(ab, n, d);
            run_xfer(ab, n, d, a);
            cmp($sformatf("rand%0d ab=%02h", t, ab), a, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) for the EEPROM path: oversamples `scl`/`sda` on the system clock, detects START/STOP, matches a fixed 7-bit address and ACKs it. Write transfers are delivered byte-by-byte to the fabric. Read transfers are served from a fabric-supplied byte on request. It sits opposite the bus initiator on the same two-wire bus and is the bench counterpart for initiator verification.

## Interface
- `DEV_ADDR`, 7'h50, 7-bit target address this block responds to.
- `SYNC_STAGES`, 2, synchronizer flops on `scl` and `sda` (≥2).
- `clk`  in  1  system clock; must be ≥10× the `scl` rate.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `scl`  in  1  bus clock, never driven (no clock stretching).
- `sda`  inout  1  bus data, open-drain: driven 0 or released to Z, never driven 1.
- `wr_data`  out  8  last byte received in a write transfer.
- `wr_valid`  out  1  one-cycle pulse; `wr_data` is valid this cycle.
- `rd_req`  out  1  one-cycle pulse requesting the next read byte.
- `rd_data`  in  8  read byte, sampled at the next `scl` falling edge after `rd_req`.
- `busy`  out  1  high from an address match until STOP, or until return to IDLE/WAIT_STOP.
- `done`  out  1  one-cycle pulse on STOP that ends an addressed transfer.

## Operation
- Protocol: MSB first; R/W bit 0 = write, 1 = read; ACK = `sda` low during the 9th clock.
- START means `sda` falls while `scl` is high. STOP means `sda` rises while `scl` is high. Both are detected on synchronized signals.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- IDLE → ADDR on START. Bit counter clears.
- ADDR: shift 8 bits on `scl` rising edges.
  - If the address equals `DEV_ADDR`: go to ADDR_ACK and assert `busy`.
  - Otherwise: go to WAIT_STOP and leave `sda` released.
- ADDR_ACK:
  - Drive `sda` low from the falling edge after bit 8 until the next falling edge.
  - If R/W=1, pulse `rd_req` at the ACK rising edge, then go to READ.
  - If R/W=0, go to WRITE.
- WRITE: shift 8 bits. On the 8th rising edge, load `wr_data` and pulse `wr_valid`, then go to WRITE_ACK. WRITE_ACK drives ACK exactly as ADDR_ACK does, then returns to WRITE. Bytes per transfer are unlimited.
- READ:
  - Latch `rd_data` into the shift register at the falling edge that ends the previous ACK slot.
  - Drive bit 7 immediately, then the next bit at each following falling edge.
  - A 1 bit means release `sda`.
- READ_ACK: release `sda` and sample it at the 9th rising edge.
  - ACK (0): pulse `rd_req` and go to READ.
  - NACK (1): go to WAIT_STOP.
- WAIT_STOP: keep `sda` released and ignore bits. Only START or STOP leaves this state.
- Repeated START in any state goes to ADDR; `busy` is held only if the new address matches.
- STOP in any state:
  - Go to IDLE, release `sda`, deassert `busy`.
  - Pulse `done` if `busy` was high.

## Timing
- Reset values:
  - state IDLE, `sda` released.
  - `wr_data`=8'h00; `wr_valid`, `rd_req`, `busy`, `done` = 0.
  - Counters and shift registers cleared.
- Reset mid-transfer aborts on the next `clk` edge, with no `done` pulse.
- Detection latency: `SYNC_STAGES`+1 `clk` cycles from a pin change to the internal event.
- `sda` drive changes only on a synchronized `scl` falling edge, so hold time after `scl` falls is ≥ `SYNC_STAGES`+1 `clk`.
- `wr_valid` fires in the cycle the 8th rising edge is detected.
- `rd_data` must be stable from the cycle after `rd_req` until the next `scl` falling edge is detected.
- START/STOP take priority over bit-edge processing in the same cycle.

## Structure
- Package `i2c_pkg`:
  - state enum.
  - `I2C_ADDR_W`=7 and `I2C_RW_READ`=1'b1.
  - byte-width constant.
- Sub-module `i2c_line_sync`: synchronizer chains and edge detect. Outputs are `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.

## Test plan
- Write 0xA0 (addr 0x50, W), then data 0x3C, 0xC3, then STOP → two `wr_valid` pulses with 0x3C then 0xC3; three ACKs low on the bus; one `done`.
- Address 0x51 on the bus → no ACK (`sda` Z at the 9th clock); `busy`=0; no `wr_valid`; no `done`.
- Read 0xA1 with `rd_data` = 0x5A then 0x96; master ACKs then NACKs → bus shows 0x5A, 0x96 MSB first; two `rd_req` pulses; `sda` released after NACK; `done` at STOP.
- Write 0xA0, data 0x11, repeated START, 0xA1, read one byte → `wr_valid` 0x11; `busy` stays high across the repeated START; read data correct.
- `rst` asserted mid-data-byte of a write → next cycle state IDLE, `sda` Z, all outputs 0; the following full write transfer succeeds.
- STOP issued mid-byte → IDLE; partial byte discarded; no `wr_valid`; `done` pulses.
